// File: rtl/midi_note_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : midi_note_tx_pkg
//  Purpose  : Shared MIDI constants, note-event word and transmit FSM state
//             encodings used by the note transmitter and the receive parser.
//  Revision : 1.0  initial release
// ============================================================================
package midi_note_tx_pkg;

    // Upper nibble of the channel-voice status bytes
    localparam logic [3:0] STATUS_NOTE_ON  = 4'h9;
    localparam logic [3:0] STATUS_NOTE_OFF = 4'h8;

    // One queued note event, 19 bits: {on, ch, note, vel}
    typedef struct packed {
        logic       on;
        logic [3:0] ch;
        logic [6:0] note;
        logic [6:0] vel;
    } midi_event_t;

    // Transmit sequencer: one ISSUE / WAIT_START / WAIT_DONE triple per byte
    typedef enum logic [3:0] {
        ST_IDLE             = 4'd0,
        ST_ISSUE_STATUS     = 4'd1,
        ST_WAIT_START_STATUS = 4'd2,
        ST_WAIT_DONE_STATUS = 4'd3,
        ST_ISSUE_NOTE       = 4'd4,
        ST_WAIT_START_NOTE  = 4'd5,
        ST_WAIT_DONE_NOTE   = 4'd6,
        ST_ISSUE_VEL        = 4'd7,
        ST_WAIT_START_VEL   = 4'd8,
        ST_WAIT_DONE_VEL    = 4'd9
    } tx_state_t;

    // Status byte for an event; a note-off may be sent as a zero-velocity note-on
    function automatic logic [7:0] midi_status(input logic on, input logic [3:0] ch,
                                               input logic off_as_zero);
        return {(on || off_as_zero) ? STATUS_NOTE_ON : STATUS_NOTE_OFF, ch};
    endfunction

    // Velocity data byte; forced to zero for a note-off sent as note-on
    function automatic logic [7:0] midi_velocity(input logic on, input logic [6:0] vel,
                                                 input logic off_as_zero);
        return (!on && off_as_zero) ? 8'h00 : {1'b0, vel};
    endfunction

endpackage
`default_nettype wire

// File: rtl/midi_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : midi_event_fifo
//  Purpose  : Note-event queue with a registered read port. The head entry is
//             presented from an output register; an entry becomes visible at
//             the head one cycle after it is written.
//  Revision : 1.0  initial release
// ============================================================================
module midi_event_fifo
    import midi_note_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  midi_event_t                wr_data,
    input  logic                       pop,
    output midi_event_t                rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    midi_event_t         r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                r_empty;
    midi_event_t         r_rd_data;

    logic                w_push;
    logic                w_pop;
    logic [AW-1:0]       w_rd_next;
    logic [CW-1:0]       w_push_ext;
    logic [CW-1:0]       w_pop_ext;

    assign full       = (r_count == CW'(DEPTH));
    assign empty      = r_empty;
    assign level      = r_count;
    assign rd_data    = r_rd_data;
    assign w_push     = push && !full;
    assign w_pop      = pop && !r_empty;
    assign w_rd_next  = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
    assign w_push_ext = {{(CW-1){1'b0}}, w_push};
    assign w_pop_ext  = {{(CW-1){1'b0}}, w_pop};

    // Storage array; written entries are only read after they are committed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the head output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_empty   <= 1'b1;
            r_rd_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr  <= w_rd_next;
            r_count   <= r_count + w_push_ext - w_pop_ext;
            // Only entries already in the array before this edge can be shown
            r_empty   <= ((r_count - w_pop_ext) == '0);
            r_rd_data <= r_mem[w_rd_next];
        end
    end

endmodule
`default_nettype wire

// File: rtl/midi_note_tx.sv
`default_nettype none
// ============================================================================
//  Module   : midi_note_tx
//  Purpose  : Queues MIDI note-on/off events and serialises each one as a
//             status / note / velocity byte sequence to a uart core, with
//             optional running status and note-off-as-zero-velocity encoding.
//  Revision : 1.0  initial release
// ============================================================================
module midi_note_tx
    import midi_note_tx_pkg::*;
#(
    parameter int FIFO_DEPTH           = 4,
    parameter int RUNNING_STATUS       = 0,
    parameter int NOTE_OFF_AS_ZERO_VEL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ev_valid,
    output logic        ev_ready,
    input  logic        ev_on,
    input  logic [3:0]  ev_channel,
    input  logic [6:0]  ev_note,
    input  logic [6:0]  ev_velocity,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    input  logic        is_transmitting,
    output logic        busy
);

    localparam logic c_OFF_ZERO = (NOTE_OFF_AS_ZERO_VEL != 0);
    localparam logic c_RUN_STAT = (RUNNING_STATUS != 0);

    tx_state_t                  r_state;
    logic                       r_transmit;
    logic [7:0]                 r_tx_byte;
    logic [6:0]                 r_note;
    logic [7:0]                 r_vel_byte;
    logic [7:0]                 r_last_status;
    logic                       r_last_valid;

    midi_event_t                w_wr_event;
    midi_event_t                w_head;
    logic                       w_full;
    logic                       w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_level;
    logic                       w_pop;
    logic [7:0]                 w_head_status;
    logic                       w_skip_status;

    assign w_wr_event    = '{on: ev_on, ch: ev_channel, note: ev_note, vel: ev_velocity};
    assign ev_ready      = !w_full;
    // A new message may only start once the uart core has gone idle
    assign w_pop         = (r_state == ST_IDLE) && !w_empty && !is_transmitting;
    assign w_head_status = midi_status(w_head.on, w_head.ch, c_OFF_ZERO);
    assign w_skip_status = c_RUN_STAT && r_last_valid && (w_head_status == r_last_status);

    assign transmit = r_transmit;
    assign tx_byte  = r_tx_byte;
    assign busy     = (w_level != '0) || (r_state != ST_IDLE);

    midi_event_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (ev_valid),
        .wr_data (w_wr_event),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .level   (w_level)
    );

    // Byte sequencer: transmit and tx_byte are loaded on entry to an ISSUE state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_transmit    <= 1'b0;
            r_tx_byte     <= 8'h00;
            r_note        <= '0;
            r_vel_byte    <= '0;
            r_last_status <= '0;
            r_last_valid  <= 1'b0;
        end else begin
            r_transmit <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_note     <= w_head.note;
                        r_vel_byte <= midi_velocity(w_head.on, w_head.vel, c_OFF_ZERO);
                        r_transmit <= 1'b1;
                        if (w_skip_status) begin
                            r_tx_byte <= {1'b0, w_head.note};
                            r_state   <= ST_ISSUE_NOTE;
                        end else begin
                            r_tx_byte     <= w_head_status;
                            r_last_status <= w_head_status;
                            r_last_valid  <= 1'b1;
                            r_state       <= ST_ISSUE_STATUS;
                        end
                    end
                end
                ST_ISSUE_STATUS:      r_state <= ST_WAIT_START_STATUS;
                ST_WAIT_START_STATUS: if (is_transmitting) r_state <= ST_WAIT_DONE_STATUS;
                ST_WAIT_DONE_STATUS: begin
                    if (!is_transmitting) begin
                        r_transmit <= 1'b1;
                        r_tx_byte  <= {1'b0, r_note};
                        r_state    <= ST_ISSUE_NOTE;
                    end
                end
                ST_ISSUE_NOTE:        r_state <= ST_WAIT_START_NOTE;
                ST_WAIT_START_NOTE:   if (is_transmitting) r_state <= ST_WAIT_DONE_NOTE;
                ST_WAIT_DONE_NOTE: begin
                    if (!is_transmitting) begin
                        r_transmit <= 1'b1;
                        r_tx_byte  <= r_vel_byte;
                        r_state    <= ST_ISSUE_VEL;
                    end
                end
                ST_ISSUE_VEL:         r_state <= ST_WAIT_START_VEL;
                ST_WAIT_START_VEL:    if (is_transmitting) r_state <= ST_WAIT_DONE_VEL;
                ST_WAIT_DONE_VEL:     if (!is_transmitting) r_state <= ST_IDLE;
                default:              r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_midi_note_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_midi_note_tx
//  Purpose  : Scoreboard bench for midi_note_tx. Three lanes run side by side:
//             lane 0 default, lane 1 running status, lane 2 note-off as 0x8n.
//             Each lane has its own uart model and byte monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_midi_note_tx;

    logic        clk;
    logic        rst;
    logic        hold_busy;
    logic        ev_on;
    logic [3:0]  ev_channel;
    logic [6:0]  ev_note;
    logic [6:0]  ev_velocity;
    logic [2:0]  ev_valid;
    logic [2:0]  ev_ready;
    logic [2:0]  transmit;
    logic [2:0]  busy;
    logic [2:0]  is_tx;
    logic [7:0]  tx_byte [3];

    int          checks;
    int          errors;
    logic [7:0]  exp_q [3][$];
    int          last_st [3];

    always #5 clk = ~clk;

    generate
        for (genvar i = 0; i < 3; i++) begin : g_lane
            logic uart_tx;

            assign is_tx[i] = uart_tx | hold_busy;

            midi_note_tx #(
                .FIFO_DEPTH           (4),
                .RUNNING_STATUS       ((i == 1) ? 1 : 0),
                .NOTE_OFF_AS_ZERO_VEL ((i == 2) ? 0 : 1)
            ) u_dut (
                .clk             (clk),
                .rst             (rst),
                .ev_valid        (ev_valid[i]),
                .ev_ready        (ev_ready[i]),
                .ev_on           (ev_on),
                .ev_channel      (ev_channel),
                .ev_note         (ev_note),
                .ev_velocity     (ev_velocity),
                .transmit        (transmit[i]),
                .tx_byte         (tx_byte[i]),
                .is_transmitting (is_tx[i]),
                .busy            (busy[i])
            );

            // uart model: busy from the cycle after transmit, for 10 cycles
            initial begin
                int  cnt;
                bit  pend;
                cnt     = 0;
                pend    = 0;
                uart_tx = 1'b0;
                forever begin
                    @(negedge clk);
                    if (cnt > 0) begin
                        cnt--;
                        if (cnt == 0) uart_tx = 1'b0;
                    end
                    if (pend) begin
                        uart_tx = 1'b1;
                        cnt     = 10;
                        pend    = 0;
                    end
                    if (transmit[i]) pend = 1;
                end
            end

            // Monitor: every transmit pulse consumes one expected byte
            initial begin
                logic [7:0] want;
                forever begin
                    @(negedge clk);
                    if (!rst && transmit[i]) begin
                        checks++;
                        if (is_tx[i]) begin
                            errors++;
                            $display("FAIL lane%0d issue_while_busy is_transmitting=%b required 0", i, is_tx[i]);
                        end
                        checks++;
                        if (exp_q[i].size() == 0) begin
                            errors++;
                            $display("FAIL lane%0d unexpected_byte got %02h required none", i, tx_byte[i]);
                        end else begin
                            want = exp_q[i].pop_front();
                            if (tx_byte[i] !== want) begin
                                errors++;
                                $display("FAIL lane%0d tx_byte got %02h required %02h", i, tx_byte[i], want);
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    // Reference model: the byte list a message produces under a lane's options
    function automatic void model_push(int l, bit on, logic [3:0] ch, logic [6:0] note,
                                       logic [6:0] vel);
        bit         rs;
        bit         nz;
        logic [7:0] st;
        logic [7:0] v;
        rs = (l == 1);
        nz = (l != 2);
        st = (on || nz) ? {4'h9, ch} : {4'h8, ch};
        v  = (!on && nz) ? 8'h00 : {1'b0, vel};
        if (!(rs && last_st[l] == int'(st))) begin
            exp_q[l].push_back(st);
            last_st[l] = int'(st);
        end
        exp_q[l].push_back({1'b0, note});
        exp_q[l].push_back(v);
    endfunction

    task automatic check_val(string name, logic [7:0] got, logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %02h required %02h", name, got, want);
        end
    endtask

    // Offer one event to the lanes in mask; returns at the negedge after the last accept
    task automatic send(logic [2:0] mask, bit on, logic [3:0] ch, logic [6:0] note,
                        logic [6:0] vel);
        logic [2:0] pend;
        logic [2:0] acc;
        int         guard;
        ev_on       = on;
        ev_channel  = ch;
        ev_note     = note;
        ev_velocity = vel;
        pend        = mask;
        guard       = 0;
        while (pend != 0 && guard < 3000) begin
            ev_valid = pend;
            acc      = pend & ev_ready;
            @(posedge clk);
            @(negedge clk);
            for (int l = 0; l < 3; l++) begin
                if (acc[l]) model_push(l, on, ch, note, vel);
            end
            pend &= ~acc;
            guard++;
        end
        ev_valid = '0;
        if (pend != 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout pending=%b required 000", pend);
        end
    endtask

    task automatic wait_quiet();
        int guard;
        guard = 0;
        while (!(exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0 &&
                 busy == 3'b000 && is_tx == 3'b000) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 5000) begin
            errors++;
            $display("FAIL drain_timeout left=%0d/%0d/%0d busy=%b required empty",
                     exp_q[0].size(), exp_q[1].size(), exp_q[2].size(), busy);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int l = 0; l < 3; l++) begin
            exp_q[l].delete();
            last_st[l] = -1;
        end
        @(negedge clk);
        check_val("reset_transmit", {5'd0, transmit}, 8'h00);
        check_val("reset_ready", {5'd0, ev_ready}, 8'h07);
        check_val("reset_busy", {5'd0, busy}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        clk         = 1'b0;
        rst         = 1'b1;
        hold_busy   = 1'b0;
        ev_valid    = '0;
        ev_on       = 1'b0;
        ev_channel  = '0;
        ev_note     = '0;
        ev_velocity = '0;
        checks      = 0;
        errors      = 0;
        @(negedge clk);
        do_reset();
        for (int l = 0; l < 3; l++) check_val("reset_tx_byte", tx_byte[l], 8'h00);

        // Note-on ch 0, note 60, vel 100: first byte 2 cycles after acceptance
        @(negedge clk);
        send(3'b111, 1'b1, 4'd0, 7'd60, 7'd100);
        check_val("latency_c0", {5'd0, transmit}, 8'h00);
        @(negedge clk);
        check_val("latency_c1", {5'd0, transmit}, 8'h00);
        @(negedge clk);
        check_val("latency_c2", {5'd0, transmit}, 8'h07);
        wait_quiet();

        // Note-off ch 3, note 64, vel 40 under both note-off encodings
        send(3'b111, 1'b0, 4'd3, 7'd64, 7'd40);
        wait_quiet();

        // Running status: two note-ons on ch 5, then ch 6
        send(3'b111, 1'b1, 4'd5, 7'd60, 7'd90);
        send(3'b111, 1'b1, 4'd5, 7'd62, 7'd91);
        send(3'b111, 1'b1, 4'd6, 7'd64, 7'd92);
        wait_quiet();

        // Back-to-back pushes into lane 0: ready drops after the fifth accept
        for (int k = 0; k < 6; k++) begin
            send(3'b001, 1'b1, 4'd2, 7'(10 + k), 7'(20 + k));
            if (k == 3) check_val("ready_after_4", {7'd0, ev_ready[0]}, 8'h01);
            if (k == 4) check_val("ready_after_5", {7'd0, ev_ready[0]}, 8'h00);
        end
        wait_quiet();

        // Reset in WAIT_DONE_NOTE with two events still queued
        send(3'b111, 1'b1, 4'd7, 7'd70, 7'd10);
        send(3'b111, 1'b1, 4'd8, 7'd71, 7'd11);
        send(3'b111, 1'b1, 4'd9, 7'd72, 7'd12);
        guard = 0;
        while (exp_q[0].size() > 7 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check_val("reach_note_byte", {7'd0, (guard < 500)}, 8'h01);
        repeat (3) @(negedge clk);
        do_reset();
        check_val("post_reset_busy", {5'd0, busy}, 8'h00);
        check_val("post_reset_ready", {5'd0, ev_ready}, 8'h07);
        repeat (30) @(negedge clk);
        send(3'b111, 1'b1, 4'd7, 7'd73, 7'd13);
        wait_quiet();

        // uart core busy across reset release with an event queued
        hold_busy = 1'b1;
        do_reset();
        send(3'b111, 1'b1, 4'd1, 7'd50, 7'd60);
        repeat (50) @(negedge clk);
        check_val("held_no_tx", 8'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 8'd9);
        check_val("held_busy", {5'd0, busy}, 8'h07);
        hold_busy = 1'b0;
        wait_quiet();

        // Randomised traffic, small channel range to exercise running status
        for (int k = 0; k < 24; k++) begin
            send(3'b111, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 2)),
                 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        wait_quiet();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/midi_note_tx.md
MIDI_NOTE_TX -- requirements
Module: midi_note_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets the number of queued note events (power of 2, minimum 2).
REQ-002 Parameter RUNNING_STATUS, default 0; when 1 the block omits a status byte equal to the last one sent.
REQ-003 Parameter NOTE_OFF_AS_ZERO_VEL, default 1; when 1 a note-off is sent as 0x9n with velocity 0, otherwise as 0x8n with the given velocity.
REQ-004 clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 ev_valid  in  1  note event offered.
REQ-007 ev_ready  out  1  event slot available; equals !fifo_full.
REQ-008 ev_on  in  1  1 = note-on, 0 = note-off.
REQ-009 ev_channel  in  4  MIDI channel 0..15.
REQ-010 ev_note  in  7  note number 0..127.
REQ-011 ev_velocity  in  7  velocity 0..127.
REQ-012 transmit  out  1  one-cycle pulse to the uart core to send tx_byte.
REQ-013 tx_byte  out  8  byte to the uart core; held stable from the transmit pulse until is_transmitting falls.
REQ-014 is_transmitting  in  1  uart core busy flag.
REQ-015 busy  out  1  high when the FIFO is non-empty or the FSM is not in IDLE.

Function
REQ-016 An event is accepted on any clk edge where ev_valid && ev_ready; its fields are written to the FIFO tail.
REQ-017 A push and a pop in the same cycle on a non-empty FIFO shall both succeed and leave the count unchanged.
REQ-018 When full, ev_ready is low and no write occurs; the FIFO is never overwritten.
REQ-019 Status byte = {4'h9, ch} for note-on, and for note-off when NOTE_OFF_AS_ZERO_VEL=1; {4'h8, ch} otherwise.
REQ-020 Data bytes are {1'b0, note} then {1'b0, vel}; vel is forced to 0 for note-off when NOTE_OFF_AS_ZERO_VEL=1.
REQ-021 FSM states and transitions:
  - IDLE: pop the FIFO head into the working register when non-empty, then go to ISSUE_STATUS.
  - ISSUE_x: go to WAIT_START_x.
  - WAIT_START_x: wait for is_transmitting=1, then go to WAIT_DONE_x.
  - WAIT_DONE_x: wait for is_transmitting=0, then go to the next byte's ISSUE_x.
  - The byte sequence is x = STATUS, NOTE, VEL; after VEL the FSM returns to IDLE.
REQ-022 transmit shall be high only for the single cycle spent in an ISSUE_x state.
REQ-023 The FSM shall not enter an ISSUE_x state while is_transmitting=1.
REQ-024 Latency: with an empty FIFO, IDLE, and is_transmitting=0, transmit for the first byte shall go high exactly 2 cycles after the accepting edge.
REQ-025 With RUNNING_STATUS=1 and a status equal to last_status, IDLE shall go directly to ISSUE_NOTE.
REQ-026 last_status updates only when a status byte is issued.
REQ-027 last_status is invalid after reset, so the first message always carries a status byte.
REQ-028 Back-to-back queued events are sent with no idle gap beyond one IDLE cycle between messages.

Reset
REQ-029 Reset values: transmit=0, tx_byte=8'h00, FSM=IDLE, FIFO empty, ev_ready=1, busy=0, last_status invalid.
REQ-030 Reset asserted mid-message aborts the message and discards the FIFO contents.
REQ-031 After a mid-message reset, the first subsequent transmit shall wait until is_transmitting=0 (per REQ-023).

Structure
REQ-032 A shared package holds the MIDI constants (STATUS_NOTE_ON=4'h9, STATUS_NOTE_OFF=4'h8) and the FSM state encodings; the receive-side parser uses the same package.
REQ-033 The FIFO is one sub-module, midi_event_fifo: 19-bit word {on, ch, note, vel}, registered read, with full and empty flags.

Verification
REQ-034 The bench's uart model asserts is_transmitting 1 cycle after transmit and holds it for 10 cycles.
REQ-035 Scenarios:
  - Note-on ch 0, note 60, vel 100 -> bytes 0x90, 0x3C, 0x64; transmit 2 cycles after accept.
  - Note-off ch 3, note 64, vel 40, default params -> 0x93, 0x40, 0x00; with NOTE_OFF_AS_ZERO_VEL=0 -> 0x83, 0x40, 0x28.
  - RUNNING_STATUS=1, two note-ons on ch 5 (notes 60, 62) -> 0x95, 0x3C, v, 0x3E, v; a following ch 6 event resends status 0x96.
  - Push 6 events back-to-back with FIFO_DEPTH=4 -> ev_ready drops after 5 accepts (4 queued + 1 popped); all accepted events are sent in order, none lost.
  - Reset during WAIT_DONE_NOTE with 2 events queued -> no further transmit, busy=0, ev_ready=1; the next event is sent with a full status byte.
  - is_transmitting held high for 50 cycles at reset release with an event queued -> no transmit until it falls.
